mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory port in the multi-cycle RISC datapath.
- Accepts a load/store request from the control FSM, computes the effective byte address as base plus offset, and range/alignment-checks it.
- Drives the memory's MemRd/MemWr/addr/dataIn lines for exactly one cycle and captures the little-endian 16-bit read word.
- Reports completion with a done pulse, plus a fault flag for rejected accesses.

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_ea_check.sv | 30 +++
 rtl/mem_access_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared types and constants for the data-memory access controller.
//   - state_e           : controller state encoding
//   - OP_LOAD/OP_STORE  : values of the op_load request bit
//   - DEFAULT_MEM_BYTES : default data-memory size in bytes
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        DONE,
        FAULT
    } state_e;

    localparam logic OP_LOAD  = 1'b1;
    localparam logic OP_STORE = 1'b0;

    localparam int unsigned DEFAULT_MEM_BYTES = 256;

endpackage

// File: rtl/mem_ea_check.sv
// -----------------------------------------------------------------------------
// mem_ea_check
//   Range and alignment check for a 16-bit word access at effective address ea.
//   A word occupies ea and ea+1, so the last legal address is MEM_BYTES-2.
//   Ports:
//     ea      in  16  effective byte address
//     illegal out  1  1 = access must be rejected
// -----------------------------------------------------------------------------
module mem_ea_check
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = DEFAULT_MEM_BYTES,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic [15:0] ea,
    output logic        illegal
);

    localparam logic [31:0] LAST_LEGAL = 32'(MEM_BYTES - 2);

    logic out_of_range;
    logic misaligned;

    always_comb begin
        out_of_range = ({16'h0000, ea} > LAST_LEGAL);
        misaligned   = ALIGN_CHECK && ea[0];
        illegal      = out_of_range || misaligned;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator side of the data-memory port. Accepts a load/store request,
//   forms ea = base + offset (mod 2^16), rejects out-of-range or misaligned
//   accesses, drives one memory cycle and captures the 16-bit read word.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     start, op_load        request strobe (sampled in IDLE), 1 = load
//     base, offset, wdata   address operands and store data
//     busy                  high whenever not IDLE
//     done, fault           one-cycle completion pulse, fault = rejected
//     rdata                 last successfully loaded word
//     mem_addr, mem_wdata   memory address / write data (held between ops)
//     MemRd, MemWr          memory read / write enables (one cycle each)
//     mem_rdata             memory read data, valid the cycle after MemRd
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = DEFAULT_MEM_BYTES,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_load,
    input  logic [15:0] base,
    input  logic [15:0] offset,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        MemRd,
    output logic        MemWr,
    input  logic [15:0] mem_rdata
);

    state_e      state_q,     state_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] rdata_q,     rdata_d;

    logic [15:0] ea;
    logic        illegal;

    // Carry out of the add is dropped on purpose: address wrap-around is legal.
    assign ea = base + offset;

    mem_ea_check #(
        .MEM_BYTES  (MEM_BYTES),
        .ALIGN_CHECK(ALIGN_CHECK)
    ) u_ea_check (
        .ea     (ea),
        .illegal(illegal)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the values from before the edge, independent of block order.
    // NOTE: the datapath registers are reset too, so mem_addr/mem_wdata/rdata
    // read back as zero after reset rather than as stale values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Address/data are latched even for a rejected access.
                    mem_addr_d  = ea;
                    mem_wdata_d = wdata;
                    if (illegal)                 state_d = FAULT;
                    else if (op_load == OP_LOAD) state_d = RD;
                    else                         state_d = WR;
                end
            end
            RD:     state_d = RD_CAP;
            RD_CAP: begin
                // Memory output is registered: the word is valid one cycle
                // after MemRd, so it is captured at the end of RD_CAP.
                rdata_d = mem_rdata;
                state_d = DONE;
            end
            WR:     state_d = DONE;
            DONE:   state_d = IDLE;
            FAULT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: decoded only from the registered state.
    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE) || (state_q == FAULT);
        fault = (state_q == FAULT);
        MemRd = (state_q == RD);
        MemWr = (state_q == WR);
    end

    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Scoreboard bench for mem_access_ctrl. Expected memory accesses and done
//   responses are queued when a request is issued; a negedge monitor pops and
//   compares them whenever the DUT strobes the memory or pulses done.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, op_load;
    logic [15:0] base, offset, wdata;
    logic        busy, done, fault, mem_rd, mem_wr;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        na_busy, na_done, na_fault, na_rd, na_wr;
    logic [15:0] na_rdata, na_addr, na_wdata;
    logic [15:0] na_mem_rdata = 16'h0000;

    mem_access_ctrl #(.MEM_BYTES(256), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op_load(op_load),
        .base(base), .offset(offset), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .MemRd(mem_rd), .MemWr(mem_wr), .mem_rdata(mem_rdata)
    );

    // Same design without the alignment check, used for odd-address cases.
    mem_access_ctrl #(.MEM_BYTES(256), .ALIGN_CHECK(1'b0)) dut_na (
        .clk(clk), .reset(reset), .start(start), .op_load(op_load),
        .base(base), .offset(offset), .wdata(wdata),
        .busy(na_busy), .done(na_done), .fault(na_fault), .rdata(na_rdata),
        .mem_addr(na_addr), .mem_wdata(na_wdata),
        .MemRd(na_rd), .MemWr(na_wr), .mem_rdata(na_mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // ---------------- physical memory seen by the DUT ----------------
    logic [7:0] phys [256];
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= {phys[mem_addr[7:0] + 8'd1], phys[mem_addr[7:0]]};
        end else begin
            mem_rdata <= 16'($urandom);
            if (mem_wr) begin
                phys[mem_addr[7:0]]        <= mem_wdata[7:0];
                phys[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct { bit fault; logic [15:0] rdata; } done_t;
    typedef struct { bit we; logic [15:0] addr; logic [15:0] data; } acc_t;

    done_t exp_done[$];
    acc_t  exp_acc[$];
    logic [7:0]  ref_mem [256];
    logic [15:0] ref_rdata = 16'h0000;

    function automatic bit is_illegal(input logic [15:0] ea);
        return (ea > 16'd254) || ea[0];
    endfunction

    // Predict the outcome of one accepted request; returns expected busy cycles.
    function automatic int predict(input bit ld, input logic [15:0] b,
                                   input logic [15:0] o, input logic [15:0] d);
        logic [15:0] ea;
        int idx;
        ea  = b + o;
        idx = int'(ea);
        if (is_illegal(ea)) begin
            exp_done.push_back('{1'b1, ref_rdata});
            return 1;
        end
        if (ld) begin
            exp_acc.push_back('{1'b0, ea, 16'h0000});
            ref_rdata = {ref_mem[idx + 1], ref_mem[idx]};
            exp_done.push_back('{1'b0, ref_rdata});
            return 3;
        end
        exp_acc.push_back('{1'b1, ea, d});
        ref_mem[idx]     = d[7:0];
        ref_mem[idx + 1] = d[15:8];
        exp_done.push_back('{1'b0, ref_rdata});
        return 2;
    endfunction

    int n_done = 0;
    int n_wr   = 0;

    always @(negedge clk) begin
        if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
            check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
            if (mem_wr === 1'b1) n_wr++;
            if (exp_acc.size() == 0) begin
                fail_now("unexpected_mem_access");
            end else begin
                acc_t a;
                a = exp_acc.pop_front();
                check("acc_kind_we", 32'(mem_wr), 32'(a.we));
                check("acc_addr", 32'(mem_addr), 32'(a.addr));
                if (a.we) check("acc_wdata", 32'(mem_wdata), 32'(a.data));
            end
        end
        if (done === 1'b1) begin
            n_done++;
            if (exp_done.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                done_t e;
                e = exp_done.pop_front();
                check("done_fault", 32'(fault), 32'(e.fault));
                check("done_rdata", 32'(rdata), 32'(e.rdata));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int guard = 0;
        while ((busy !== 1'b0 || na_busy !== 1'b0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) fail_now("wait_idle_timeout");
    endtask

    task automatic issue(input bit ld, input logic [15:0] b,
                         input logic [15:0] o, input logic [15:0] d);
        int exp_busy, busy_cnt, guard;
        @(negedge clk);
        op_load = ld; base = b; offset = o; wdata = d; start = 1'b1;
        exp_busy = predict(ld, b, o, d);
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            busy_cnt++;
            guard++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        logic [15:0] ea, b;

        for (int i = 0; i < 256; i++) begin
            phys[i]    = 8'($urandom);
            ref_mem[i] = phys[i];
        end
        reset = 1'b1; start = 1'b0; op_load = 1'b0;
        base = 16'h0; offset = 16'h0; wdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_memrd_memwr", 32'({mem_rd, mem_wr}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b0;

        // Basic store then load of the same word.
        issue(1'b0, 16'h0010, 16'h0004, 16'hBEEF);
        check("held_mem_addr", 32'(mem_addr), 32'h0014);
        check("held_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        issue(1'b1, 16'h0010, 16'h0004, 16'h0000);
        check("load_rdata_held", 32'(rdata), 32'hBEEF);

        // Address arithmetic: negative offset and 16-bit wrap.
        issue(1'b0, 16'h0020, 16'hFFFE, 16'h1357);
        issue(1'b1, 16'h0020, 16'hFFFE, 16'h0000);
        issue(1'b0, 16'hFFFF, 16'h0003, 16'h2468);
        issue(1'b1, 16'hFFFF, 16'h0003, 16'h0000);

        // Bounds: last legal word, first out-of-range address.
        issue(1'b0, 16'h00F0, 16'h000E, 16'hA5C3);
        issue(1'b1, 16'h00F0, 16'h000E, 16'h0000);
        issue(1'b1, 16'h0100, 16'h0000, 16'h0000);
        check("fault_keeps_rdata", 32'(rdata), 32'hA5C3);

        // Odd address: fault with alignment check, normal write without it.
        wait_idle();
        @(negedge clk);
        op_load = 1'b0; base = 16'h0010; offset = 16'h0001; wdata = 16'h7777; start = 1'b1;
        void'(predict(1'b0, 16'h0010, 16'h0001, 16'h7777));
        @(negedge clk);
        start = 1'b0;
        check("na_memwr", 32'(na_wr), 32'd1);
        check("na_addr", 32'(na_addr), 32'h0011);
        @(negedge clk);
        check("na_done", 32'(na_done), 32'd1);
        check("na_fault", 32'(na_fault), 32'd0);
        wait_idle();

        // Start pulsed during RD_CAP is ignored.
        d0 = n_done;
        @(negedge clk);
        op_load = 1'b1; base = 16'h0000; offset = 16'h0014; start = 1'b1;
        void'(predict(1'b1, 16'h0000, 16'h0014, 16'h0000));
        @(negedge clk);            // RD
        start = 1'b0;
        @(negedge clk);            // RD_CAP
        op_load = 1'b0; base = 16'h0040; offset = 16'h0000; wdata = 16'hDEAD; start = 1'b1;
        @(negedge clk);            // DONE
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rdcap_start_done_count", 32'(n_done - d0), 32'd1);

        // Start held for 12 edges: one store accepted every 3 cycles.
        wait_idle();
        d0 = n_done; w0 = n_wr;
        @(negedge clk);
        op_load = 1'b0; base = 16'h0030; offset = 16'h0002; wdata = 16'h1234; start = 1'b1;
        for (int k = 0; k < (12 + 2) / 3; k++) void'(predict(1'b0, 16'h0030, 16'h0002, 16'h1234));
        repeat (12) @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("held_start_wr_count", 32'(n_wr - w0), 32'd4);
        check("held_start_done_count", 32'(n_done - d0), 32'd4);

        // Reset during RD_CAP: back to IDLE, registers cleared, no done.
        @(negedge clk);
        op_load = 1'b1; base = 16'h0014; offset = 16'h0000; start = 1'b1;
        void'(predict(1'b1, 16'h0014, 16'h0000, 16'h0000));
        @(negedge clk);            // RD
        start = 1'b0;
        @(negedge clk);            // RD_CAP
        reset = 1'b1;
        exp_done.delete();
        ref_rdata = 16'h0000;
        d0 = n_done;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        issue(1'b1, 16'h0010, 16'h0004, 16'h0000);
        check("post_rst_load", 32'(rdata), 32'hBEEF);

        // Randomized mix of loads, stores and rejected accesses.
        for (int n = 0; n < 60; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) ea = 16'($urandom_range(255, 65535));
            else        ea = 16'($urandom_range(0, 127) * 2);
            if (r == 1) ea[0] = 1'b1;
            b = 16'($urandom);
            wait_idle();
            issue(bit'($urandom_range(0, 1)), b, ea - b, 16'($urandom));
        end

        repeat (5) @(negedge clk);
        check("exp_done_drained", 32'(exp_done.size()), 32'd0);
        check("exp_acc_drained", 32'(exp_acc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
